// File: rtl/board_key_debounce.sv
// Board key front end: two-flop synchroniser, per-channel debounce, press/release
// pulses with optional auto-repeat, and sticky write-1-to-clear press flags.
module board_key_debounce #(
  parameter int DATA_WIDTH      = 8,
  parameter int KEY_WIDTH       = 6,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] ext_board_key,
  output logic signed [DATA_WIDTH-1:0] data,
  output logic        [KEY_WIDTH-1:0]  pressed,
  output logic        [KEY_WIDTH-1:0]  released,
  output logic signed [DATA_WIDTH-1:0] event_data,
  input  logic        [KEY_WIDTH-1:0]  event_clear,
  output logic                         event_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_W = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]     RPT_LAST  = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  // Synchroniser resets to the released pin level so nothing looks pressed after reset.
  localparam logic [KEY_WIDTH-1:0] IDLE_PINS = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [KEY_WIDTH-1:0] sync1_q, sync1_d;
  logic [KEY_WIDTH-1:0] sync2_q, sync2_d;
  logic [KEY_WIDTH-1:0] key_level;
  logic [KEY_WIDTH-1:0] state_vec;
  logic [KEY_WIDTH-1:0] event_q, event_d;
  logic                 event_valid_q, event_valid_d;
  logic                 unused_pins;

  assign unused_pins = ^ext_board_key;

  always_comb begin
    sync1_d = ext_board_key[KEY_WIDTH-1:0];
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_PINS;
      sync2_q <= IDLE_PINS;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign key_level = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_WIDTH; gi++) begin : g_key
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [RPT_W-1:0] rpt_q, rpt_d;
      logic             state_q, state_d;
      logic             press_q, press_d;
      logic             release_q, release_d;

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (key_level[gi] == state_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = key_level[gi];
          cnt_d     = '0;
          press_d   = key_level[gi];
          release_d = ~key_level[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // Repeat timer runs only while the key stays held; any transition restarts it.
        if (!state_q || (state_d != state_q)) begin
          rpt_d = '0;
        end else if (REPEAT_CYCLES > 0) begin
          if (rpt_q == RPT_LAST) begin
            rpt_d   = '0;
            press_d = 1'b1;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q   <= 1'b0;
          cnt_q     <= '0;
          rpt_q     <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          rpt_q     <= rpt_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      assign state_vec[gi] = state_q;
      assign pressed[gi]   = press_q;
      assign released[gi]  = release_q;
    end
  endgenerate

  // A press landing in the same cycle as its clear keeps the flag set.
  always_comb begin
    event_d       = (event_q & ~event_clear) | pressed;
    event_valid_d = |event_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q       <= '0;
      event_valid_q <= 1'b0;
    end else begin
      event_q       <= event_d;
      event_valid_q <= event_valid_d;
    end
  end

  assign data        = DATA_WIDTH'(state_vec);
  assign event_data  = DATA_WIDTH'(event_q);
  assign event_valid = event_valid_q;

endmodule

// File: tb/tb_board_key_debounce.sv
// Directed bench: one instance without auto-repeat, one with an 8-cycle repeat.
module tb_board_key_debounce;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key, key_r;
  logic [7:0] data, data_r, event_data, event_data_r;
  logic [5:0] pressed, released, pressed_r, released_r;
  logic [5:0] event_clear, event_clear_r;
  logic       event_valid, event_valid_r;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  board_key_debounce #(.DATA_WIDTH(8), .KEY_WIDTH(6), .ACTIVE_LOW(1),
                       .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .ext_board_key(key), .data(data),
    .pressed(pressed), .released(released), .event_data(event_data),
    .event_clear(event_clear), .event_valid(event_valid));

  board_key_debounce #(.DATA_WIDTH(8), .KEY_WIDTH(6), .ACTIVE_LOW(1),
                       .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut_r (
    .clk(clk), .reset(reset), .ext_board_key(key_r), .data(data_r),
    .pressed(pressed_r), .released(released_r), .event_data(event_data_r),
    .event_clear(event_clear_r), .event_valid(event_valid_r));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    $display("[%0t] check %s got=%0h exp=%0h", $time, tag, got, exp);
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; key = 8'hFF; key_r = 8'hFF;
    event_clear = '0; event_clear_r = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_data", data, 8'h00);
    chk("rst_pressed", pressed, 6'h00);
    chk("rst_released", released, 6'h00);
    chk("rst_event", event_data, 8'h00);
    chk("rst_valid", event_valid, 1'b0);

    // 1: press bit0, registers on edge 6
    key = 8'hFE;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_wait_data", data, 8'h00);
      chk("t1_wait_pressed", pressed, 6'h00);
    end
    tick();
    chk("t1_data", data, 8'h01);
    chk("t1_pressed", pressed, 6'h01);
    chk("t1_valid_early", event_valid, 1'b0);
    tick();
    chk("t1_pressed_gone", pressed, 6'h00);
    chk("t1_event", event_data, 8'h01);
    chk("t1_valid_lag", event_valid, 1'b0);
    tick();
    chk("t1_valid", event_valid, 1'b1);

    // 3: release bit0, then clear its flag
    key = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t3_wait_data", data, 8'h01);
      chk("t3_wait_released", released, 6'h00);
    end
    tick();
    chk("t3_data", data, 8'h00);
    chk("t3_released", released, 6'h01);
    chk("t3_no_press", pressed, 6'h00);
    tick();
    chk("t3_released_gone", released, 6'h00);
    chk("t3_event_sticky", event_data, 8'h01);
    event_clear = 6'h01;
    tick();
    event_clear = 6'h00;
    chk("t3_event_cleared", event_data, 8'h00);
    chk("t3_valid_lag", event_valid, 1'b1);
    tick();
    chk("t3_valid_cleared", event_valid, 1'b0);

    // 2: bit2 glitches (3 low, 1 high) then a sustained press
    key = 8'hFB;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t2_glitch_data", data, 8'h00);
      chk("t2_glitch_pressed", pressed, 6'h00);
    end
    key = 8'hFF;
    tick();
    chk("t2_gap_data", data, 8'h00);
    key = 8'hFB;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t2_wait_data", data, 8'h00);
      chk("t2_wait_pressed", pressed, 6'h00);
    end
    tick();
    chk("t2_data", data, 8'h04);
    chk("t2_pressed", pressed, 6'h04);
    tick();
    chk("t2_single_pulse", pressed, 6'h00);
    event_clear = 6'h04;
    tick();
    event_clear = 6'h00;
    chk("t2_event_cleared", event_data, 8'h00);

    // 4: clear bit1 in the cycle its press pulse is out; set must win
    key = 8'hF9;
    repeat (5) tick();
    tick();
    chk("t4_pressed", pressed, 6'h02);
    chk("t4_data", data, 8'h06);
    event_clear = 6'h02;
    tick();
    event_clear = 6'h00;
    chk("t4_set_wins", event_data, 8'h02);
    event_clear = 6'h01;
    tick();
    event_clear = 6'h00;
    chk("t4_clear_idle_bit", event_data, 8'h02);
    key = 8'hFF;
    repeat (5) tick();
    tick();
    chk("t4_multi_released", released, 6'h06);
    chk("t4_multi_data", data, 8'h00);

    // 6: reset in the middle of a bit5 debounce
    key = 8'hDF;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t6_rst_pressed", pressed, 6'h00);
      chk("t6_rst_data", data, 8'h00);
      chk("t6_rst_event", event_data, 8'h00);
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t6_wait_pressed", pressed, 6'h00);
    end
    tick();
    chk("t6_pressed", pressed, 6'h20);
    chk("t6_data", data, 8'h20);
    tick();
    chk("t6_event", event_data, 8'h20);

    // 5: auto-repeat every 8 cycles on bit3
    key_r = 8'hF7;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t5_wait_pressed", pressed_r, 6'h00);
    end
    tick();
    chk("t5_first_press", pressed_r, 6'h08);
    for (int k = 1; k <= 33; k++) begin
      tick();
      chk("t5_repeat", pressed_r, (k % 8 == 0) ? 6'h08 : 6'h00);
    end
    key_r = 8'hFF;
    for (int k = 34; k <= 38; k++) begin
      tick();
      chk("t5_hold_tail", pressed_r, 6'h00);
      chk("t5_hold_data", data_r, 8'h08);
    end
    tick();
    chk("t5_released", released_r, 6'h08);
    chk("t5_release_no_press", pressed_r, 6'h00);
    chk("t5_release_data", data_r, 8'h00);
    for (int k = 40; k <= 50; k++) begin
      tick();
      chk("t5_quiet_pressed", pressed_r, 6'h00);
      chk("t5_quiet_released", released_r, 6'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_key_debounce.md
Name: board_key_debounce

Overview:
- Parametrised successor to the plain key synchroniser on the board key path.
- Synchronises KEY_WIDTH raw board keys into the clk domain, debounces each channel independently, and normalises polarity so that pressed reads 1.
- Produces one-cycle press/release pulses, optional auto-repeat, and sticky per-key event flags with write-1-to-clear.
- Sits between the board key pins and the CPU/peripheral bus; `data` and `event_data` are read as sign-typed DATA_WIDTH words, zero-extended.

Parameters:
- DATA_WIDTH, 8: width of `ext_board_key`, `data` and `event_data`.
- KEY_WIDTH, 6: number of key channels, 1..DATA_WIDTH.
- ACTIVE_LOW, 1: 1 means a raw pin level of 0 is pressed (input is inverted after synchronisation); 0 means no inversion.
- DEBOUNCE_CYCLES, 50000: consecutive differing samples required before a state change; must be ≥2. Counter width is $clog2(DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 0: 0 disables auto-repeat; otherwise it is the period, in cycles, of repeat press pulses while a key is held. Counter width is $clog2(REPEAT_CYCLES+1).

Ports:
- clk, input, 1: system clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- ext_board_key, input, DATA_WIDTH (signed): raw asynchronous key pins; only bits [KEY_WIDTH-1:0] are used.
- data, output, DATA_WIDTH (signed): debounced pressed levels, zero-extended above KEY_WIDTH.
- pressed, output, KEY_WIDTH: one-cycle pulse per press, and per repeat.
- released, output, KEY_WIDTH: one-cycle pulse per release.
- event_data, output, DATA_WIDTH (signed): sticky press flags, zero-extended.
- event_clear, input, KEY_WIDTH: write-1-to-clear strobe for `event_data`, sampled every cycle.
- event_valid, output, 1: registered OR of all sticky flags.

Behaviour:
- Synchroniser:
  - Two flops per channel, then polarity normalisation.
  - On reset, the flops load the inactive pin level (1 if ACTIVE_LOW). This guarantees no spurious press after reset.
- Debounce state, per channel: `state` (pressed level) and counter `cnt`.
  - If the synchronised value equals `state`: `cnt` <= 0.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: `state` <= new value and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any mismatch run shorter than DEBOUNCE_CYCLES is discarded, and the counter restarts from 0 on the next mismatch.
- Latency:
  - Take edge 1 as the first edge that samples the new pin value.
  - `state`, `data` and the pulse all update at edge DEBOUNCE_CYCLES+2.
- Pulses:
  - `pressed[i]` is high for exactly the one cycle after the edge where `state[i]` goes 0→1.
  - `released[i]` is the same for 1→0.
  - A channel never asserts `pressed` and `released` in the same cycle.
  - All outputs are registered.
- Auto-repeat (REPEAT_CYCLES>0):
  - A per-channel repeat counter is cleared on the 0→1 transition.
  - While `state`=1 it increments each cycle. On reaching REPEAT_CYCLES it asserts `pressed[i]` for one cycle and reloads to 0.
  - The first repeat pulse therefore arrives REPEAT_CYCLES cycles after the initial press pulse.
  - The counter is held at 0 while `state`=0.
- Sticky events:
  - `event[i]` is set on every `pressed[i]` condition, including repeats.
  - It is cleared by `event_clear[i]`=1.
  - If set and clear occur in the same cycle for the same bit, set wins.
  - Clearing an already-clear bit has no effect.
  - `event_valid` updates one cycle after `event_data` changes.
- Reset:
  - All outputs are 0; `state`, counters and events are 0.
  - Reset asserted mid-debounce or mid-repeat abandons the count with no pulse.
  - A key held through reset release is reported as a press at edge DEBOUNCE_CYCLES+2 after reset deassertion. It produces a `pressed` pulse and sets the sticky flag.
- Channels are fully independent; simultaneous transitions on several keys produce simultaneous pulses.
- `data` and `event_data` bits [DATA_WIDTH-1:KEY_WIDTH] are always 0.

Test Plan:
All scenarios use DATA_WIDTH=8, KEY_WIDTH=6, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0 unless stated otherwise.
1. Reset with `ext_board_key`=8'hFF, then drive bit0 low from edge 1 → at edge 6, `data`=8'h01 and `pressed`=6'b000001 for one cycle; `event_data`=8'h01 and `event_valid`=1 one cycle later.
2. Drive bit2 low for 3 cycles, high for 1, then low for 3 → `data` stays 0 with no pulses. Then hold bit2 low for 4 cycles → `data`=8'h04 and a single `pressed` pulse.
3. With bit0 debounced pressed, release the pin → `released`=6'b000001 for one cycle at edge 6; `data`=0; `event_data` is still 8'h01. Pulse `event_clear`=6'b000001 → `event_data`=0, then `event_valid`=0 one cycle later.
4. On the same cycle a new press on bit1 registers, assert `event_clear`=6'b000010 → `event_data` bit1 remains 1 (set wins).
5. Set REPEAT_CYCLES=8 and hold bit3 for 40 cycles after the press pulse → `pressed[3]` pulses at +0, +8, +16, +24, +32. On release: one `released` pulse and no further repeats.
6. Hold bit5 low, assert reset for 3 cycles mid-debounce, then deassert → no pulse during or immediately after reset; `pressed[5]` pulses at edge 6 after deassertion.
